// File: rtl/activation_argmax.sv
// Sequential argmax over the MLP output layer: scans one class per cycle from a
// snapshot, reports the winning digit, its activation, the margin and a 7-segment pattern.
module activation_argmax #(
    parameter int resolution       = 8,
    parameter int classes_nr       = 10,
    parameter int margin_threshold = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [resolution*classes_nr-1:0] output_activations,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [3:0]                       digit,
    output logic [resolution-1:0]            max_activation,
    output logic [resolution-1:0]            margin,
    output logic                             confident,
    output logic                             result_valid,
    output logic [6:0]                       segments
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] last_idx = 4'(classes_nr - 1);

    state_t                state_r;
    logic [resolution-1:0] snap_r [classes_nr];
    logic [resolution-1:0] best_r;
    logic [resolution-1:0] second_r;
    logic [3:0]            best_idx_r;
    logic [3:0]            index_r;
    logic                  busy_r;
    logic                  done_r;
    logic [3:0]            digit_r;
    logic [resolution-1:0] max_r;
    logic [resolution-1:0] margin_r;
    logic                  confident_r;
    logic                  valid_r;

    logic                  accept_s;
    logic [resolution-1:0] cur_s;
    logic [resolution-1:0] nbest_s;
    logic [resolution-1:0] nsecond_s;
    logic [3:0]            nidx_s;
    logic [resolution-1:0] margin_s;
    logic [6:0]            segments_s;

    assign accept_s = start && (state_r != SCAN);

    // Next best/second candidates; equal-to-best only demotes to second so the lowest index keeps the win.
    always_comb begin
        cur_s     = snap_r[index_r];
        nbest_s   = best_r;
        nsecond_s = second_r;
        nidx_s    = best_idx_r;
        if (cur_s > best_r) begin
            nbest_s   = cur_s;
            nsecond_s = best_r;
            nidx_s    = index_r;
        end else if (cur_s > second_r) begin
            nsecond_s = cur_s;
        end else begin
            nsecond_s = second_r;
        end
        margin_s = nbest_s - nsecond_s;
    end

    // Control FSM, scan datapath and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            for (int i = 0; i < classes_nr; i++) begin
                snap_r[i] <= {resolution{1'b0}};
            end
            best_r      <= {resolution{1'b0}};
            second_r    <= {resolution{1'b0}};
            best_idx_r  <= 4'd0;
            index_r     <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            digit_r     <= 4'd0;
            max_r       <= {resolution{1'b0}};
            margin_r    <= {resolution{1'b0}};
            confident_r <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                for (int i = 0; i < classes_nr; i++) begin
                    snap_r[i] <= output_activations[resolution*i +: resolution];
                end
                best_r     <= output_activations[resolution-1:0];
                second_r   <= {resolution{1'b0}};
                best_idx_r <= 4'd0;
                index_r    <= 4'd1;
                busy_r     <= 1'b1;
                state_r    <= SCAN;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    SCAN: begin
                        best_r     <= nbest_s;
                        second_r   <= nsecond_s;
                        best_idx_r <= nidx_s;
                        index_r    <= index_r + 4'd1;
                        if (index_r == last_idx) begin
                            digit_r     <= nidx_s;
                            max_r       <= nbest_s;
                            margin_r    <= margin_s;
                            confident_r <= (margin_s >= resolution'(margin_threshold));
                            valid_r     <= 1'b1;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            state_r <= SCAN;
                        end
                    end
                    DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Active-low gfedcba decode of the registered digit; blank until a result exists.
    always_comb begin
        segments_s = 7'b1111111;
        if (!valid_r) begin
            segments_s = 7'b1111111;
        end else begin
            case (digit_r)
                4'd0:    segments_s = 7'b1000000;
                4'd1:    segments_s = 7'b1111001;
                4'd2:    segments_s = 7'b0100100;
                4'd3:    segments_s = 7'b0110000;
                4'd4:    segments_s = 7'b0011001;
                4'd5:    segments_s = 7'b0010010;
                4'd6:    segments_s = 7'b0000010;
                4'd7:    segments_s = 7'b1111000;
                4'd8:    segments_s = 7'b0000000;
                4'd9:    segments_s = 7'b0010000;
                default: segments_s = 7'b1111111;
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign digit          = digit_r;
    assign max_activation = max_r;
    assign margin         = margin_r;
    assign confident      = confident_r;
    assign result_valid   = valid_r;
    assign segments       = segments_s;

endmodule

// File: doc/activation_argmax.md
ACTIVATION_ARGMAX -- requirements
Module: activation_argmax

Interface
REQ-001 Parameter resolution, default 8, bit width of one activation.
REQ-002 Parameter classes_nr, default 10, number of output classes (digits 0..9).
REQ-003 Parameter margin_threshold, default 16, minimum best-minus-second-best margin for a confident result.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 output_activations  input  resolution*classes_nr  unsigned activations from the MLP; class i occupies bits [resolution*i +: resolution].
REQ-007 start  input  1  request to classify the current output_activations.
REQ-008 busy  output  1  high while a scan is in progress.
REQ-009 done  output  1  one-cycle pulse when a new result is registered.
REQ-010 digit  output  4  index of the winning class.
REQ-011 max_activation  output  resolution  winning activation value.
REQ-012 margin  output  resolution  max_activation minus second-highest activation.
REQ-013 confident  output  1  high when margin >= margin_threshold.
REQ-014 result_valid  output  1  high once any result has been produced since reset.
REQ-015 segments  output  7  active-low gfedcba seven-segment pattern of digit.

Function
REQ-016 FSM states: IDLE, SCAN, DONE.
REQ-017 start is accepted only when busy=0 (IDLE or DONE); start while busy=1 is ignored, no queuing.
REQ-018 On accept: snapshot full output_activations into an internal register; best=act[0], best_idx=0, second=0, index=1; go to SCAN; busy=1.
REQ-019 Input changes after acceptance do not affect the running scan; only the snapshot is used.
REQ-020 SCAN: one class per cycle, index 1..classes_nr-1, compare against snapshot.
REQ-021 If act[index] > best (strict): second<=best, best<=act[index], best_idx<=index.
REQ-022 Else if act[index] > second: second<=act[index].
REQ-023 Ties: equal to best never replaces best; lowest index wins; the equal value becomes second, giving margin 0.
REQ-024 On the edge processing index classes_nr-1: register digit, max_activation, margin=best-second (unsigned, never negative), confident; set result_valid=1; go to DONE.
REQ-025 DONE lasts exactly one cycle: done=1, busy=0; then IDLE unless start is accepted in DONE (back-to-back, start in DONE -> SCAN).
REQ-026 Latency: start sampled at edge k -> done high during the cycle following edge k+classes_nr-1 (k+9 at default); busy high from edge k until edge k+9.
REQ-027 Outputs digit/max_activation/margin/confident hold their value until the next DONE; they do not change during SCAN.
REQ-028 segments: combinational decode of registered digit (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); 1111111 (blank) when result_valid=0 or digit>9.
REQ-029 All arithmetic in resolution bits, unsigned; no overflow possible since best >= second.

Reset
REQ-030 reset asserted: state=IDLE, busy=0, done=0, digit=0, max_activation=0, margin=0, confident=0, result_valid=0, segments=1111111, snapshot and scan registers cleared, immediately without a clock edge.
REQ-031 reset mid-SCAN aborts the scan; no done pulse; previous results are cleared, not retained.
REQ-032 start held high during reset and at release is sampled only at the first rising edge after reset deasserts.

Verification
REQ-033 act = {9:5,8:5,7:5,6:5,5:5,4:5,3:200,2:5,1:5,0:5}, start 1 cycle -> done 9 cycles after acceptance, digit=3, max=200, margin=195, confident=1, segments=0110000.
REQ-034 act[2]=act[7]=120, rest 10 -> digit=2, max=120, margin=0, confident=0.
REQ-035 act[9]=255, act[0]=240, rest 0 -> digit=9, margin=15, confident=0; then act[9]=255, act[0]=239 -> margin=16, confident=1.
REQ-036 start pulsed again at SCAN cycle 4 and inputs changed mid-scan -> ignored, result from snapshot; start asserted continuously -> done every 10 cycles, busy low only in DONE cycle.
REQ-037 reset asserted at SCAN cycle 5 -> all outputs to reset values asynchronously, no done, segments blank; new start after release completes normally.
REQ-038 All activations 0 -> digit=0, max=0, margin=0, confident=0, result_valid=1, segments=1000000.
